axi_ad9364_dac_sched: RTL

//  - Slot scheduler in front of the AD9364 digital interface DAC port (dac_valid/dac_data_*).
//  - Arbitrates two sample sources (src0 = DDS, src1 = DMA) onto the interface at a programmed slot rate.
//  - Handles 1T (r1) and 2T framing, and counts underflows.
//  - Sits in the clk domain between the sample generators and the digital interface.

---
 rtl/axi_ad9364_dac_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axi_ad9364_dac_sched.sv
// Slot scheduler for the AD9364 DAC port: arbitrates DDS (src0) and DMA (src1) samples onto
// periodic slots. Optional internal test pattern on cfg_src_sel = 11: AXI_AD9364_DAC_SCHED_PATTERN_EN.
module axi_ad9364_dac_sched #(
  parameter int RATE_W = 4,
  parameter int UFL_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_enable,
  input  logic              cfg_r1_mode,
  input  logic [RATE_W-1:0] cfg_rate_div,
  input  logic [1:0]        cfg_src_sel,
  input  logic              cfg_ufl_clr,
  input  logic              src0_valid,
  input  logic [47:0]       src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [47:0]       src1_data,
  output logic              src1_ready,
  output logic              dac_valid,
  output logic [11:0]       dac_data_i1,
  output logic [11:0]       dac_data_q1,
  output logic [11:0]       dac_data_i2,
  output logic [11:0]       dac_data_q2,
  output logic              dac_r1_mode,
  output logic [UFL_W-1:0]  ufl_cnt,
  output logic              ufl_sticky
);

  logic [RATE_W-1:0] r_cnt;
  logic [RATE_W-1:0] r_rate_div;
  logic [1:0]        r_src_sel;
  logic              r_rr_last;
  logic [RATE_W-1:0] w_min;
  logic [RATE_W-1:0] w_last;
  logic              w_slot;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_pat;
  logic              w_ufl;
  logic [47:0]       w_data;
`ifdef AXI_AD9364_DAC_SCHED_PATTERN_EN
  logic              r_pat_b;
`endif

  // Slot timing, round-robin grant and the sample that the slot will present
  always_comb begin
    w_min  = dac_r1_mode ? RATE_W'(1) : RATE_W'(3);
    w_last = (r_rate_div < w_min) ? w_min : r_rate_div;
    w_slot = rstn & cfg_enable & (r_cnt == '0);
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_pat  = 1'b0;
    case (r_src_sel)
      2'b01: w_gnt1 = src1_valid;
      2'b10: begin
        if (r_rr_last) begin
          w_gnt0 = src0_valid;
          w_gnt1 = ~src0_valid & src1_valid;
        end else begin
          w_gnt1 = src1_valid;
          w_gnt0 = ~src1_valid & src0_valid;
        end
      end
`ifdef AXI_AD9364_DAC_SCHED_PATTERN_EN
      2'b11: w_pat = 1'b1;
`endif
      default: w_gnt0 = src0_valid;
    endcase
    w_ufl = w_slot & ~(w_gnt0 | w_gnt1 | w_pat);
    if (w_gnt0) begin
      w_data = src0_data;
    end else if (w_gnt1) begin
      w_data = src1_data;
`ifdef AXI_AD9364_DAC_SCHED_PATTERN_EN
    end else if (w_pat) begin
      w_data = r_pat_b ? {12'o4402, 12'o1337, 12'o4402, 12'o1337}
                       : {12'o2064, 12'o1753, 12'o2064, 12'o1753};
`endif
    end else begin
      w_data = 48'd0;
    end
    if (dac_r1_mode) begin
      w_data[23:0] = 24'd0;
    end else begin
      w_data[23:0] = w_data[23:0];
    end
  end

  assign src0_ready = w_slot & w_gnt0;
  assign src1_ready = w_slot & w_gnt1;

  // Slot counter and shadow configuration; shadows reload only while idle or on a slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_rate_div  <= '0;
      r_src_sel   <= 2'b00;
      dac_r1_mode <= 1'b0;
      r_rr_last   <= 1'b1;
    end else begin
      if (!cfg_enable || r_cnt == w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + RATE_W'(1);
      end
      if (!cfg_enable || w_slot) begin
        r_rate_div  <= cfg_rate_div;
        r_src_sel   <= cfg_src_sel;
        dac_r1_mode <= cfg_r1_mode;
      end
      if (w_slot && (w_gnt0 || w_gnt1)) begin
        r_rr_last <= w_gnt1;
      end
    end
  end

`ifdef AXI_AD9364_DAC_SCHED_PATTERN_EN
  // Pattern phase restarts at A whenever the scheduler is disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pat_b <= 1'b0;
    end else if (!cfg_enable) begin
      r_pat_b <= 1'b0;
    end else if (w_slot && w_pat) begin
      r_pat_b <= ~r_pat_b;
    end
  end
`endif

  // Registered DAC strobe and data; data holds between slots
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dac_valid   <= 1'b0;
      dac_data_i1 <= 12'd0;
      dac_data_q1 <= 12'd0;
      dac_data_i2 <= 12'd0;
      dac_data_q2 <= 12'd0;
    end else begin
      dac_valid <= w_slot;
      if (w_slot) begin
        {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2} <= w_data;
      end
    end
  end

  // Underflow counter: a clear coinciding with an underflow leaves a count of one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ufl_cnt    <= '0;
      ufl_sticky <= 1'b0;
    end else if (cfg_ufl_clr) begin
      ufl_cnt    <= w_ufl ? UFL_W'(1) : '0;
      ufl_sticky <= w_ufl;
    end else if (w_ufl) begin
      ufl_sticky <= 1'b1;
      if (ufl_cnt != '1) begin
        ufl_cnt <= ufl_cnt + UFL_W'(1);
      end
    end
  end

endmodule
